nonce_sequencer: RTL and testbench
==================================

NONCE_SEQUENCER -- requirements
Module: nonce_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 300, meaning max cycles in WAIT for core_done before error (legal 1..1023).
REQ-002 SHALL have ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request to begin a sweep.
abort  in  1  cancel the sweep in progress.
header_in  in  376  message prefix (bits 407:32 of the core message).
target_in  in  256  difficulty target, unsigned.
nonce_first  in  32  first nonce of the range.
nonce_last  in  32  last nonce of the range, inclusive.
core_start  out  1  one-cycle launch pulse to the SHA core.
core_msg  out  408  {header, nonce} message to the core.
core_done  in  1  one-cycle completion pulse from the core.
core_hash  in  256  core digest, valid when core_done=1.
busy  out  1  sweep in progress.
found  out  1  winning nonce located.
exhausted  out  1  range finished with no winner.
timeout_err  out  1  core failed to respond.
found_nonce  out  32  winning nonce.
found_hash  out  256  digest of the winning nonce.

Function
REQ-003 SHALL have states IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUST, ERROR; FOUND, EXHAUST and ERROR are terminal and behave as IDLE for accepting start.
REQ-004 In IDLE or a terminal state with start=1 and abort=0: SHALL latch header_in, target_in, nonce_first into cur_nonce, and nonce_last; clear found, exhausted, timeout_err; go to ISSUE.
REQ-005 start SHALL be ignored in ISSUE, WAIT and CHECK; header/target/range changes after the latch SHALL have no effect.
REQ-006 ISSUE lasts exactly one cycle: core_start=1, then WAIT; core_start SHALL be 0 in every other state.
REQ-007 core_msg SHALL equal {latched header, cur_nonce} and stay constant from ISSUE until the matching core_done.
REQ-008 In WAIT with core_done=1: core_hash SHALL be registered and the state SHALL go to CHECK; core_done in any other state SHALL be ignored.
REQ-009 In CHECK: if registered hash < latched target (unsigned, strict), SHALL go to FOUND with found_nonce=cur_nonce and found_hash=hash.
REQ-010 If no win and cur_nonce==nonce_last, SHALL go to EXHAUST; otherwise cur_nonce SHALL increment mod 2^32 (FFFFFFFF wraps to 00000000) and the state SHALL go to ISSUE.
REQ-011 Hash equal to target SHALL NOT count as a win.
REQ-012 Gap from a sampled core_done to the next core_start SHALL be exactly 2 cycles (CHECK, then ISSUE).
REQ-013 If nonce_last precedes nonce_first numerically, the sweep SHALL wrap through FFFFFFFF and stop at nonce_last.
REQ-014 WAIT SHALL count cycles from 0 on entry; if TIMEOUT cycles pass with no core_done, SHALL go to ERROR with timeout_err=1.
REQ-015 abort=1 in any state SHALL go to IDLE on the next edge with busy=0 and found/exhausted/timeout_err unchanged; abort SHALL win over simultaneous start or core_done.
REQ-016 busy SHALL be 1 exactly in ISSUE, WAIT and CHECK.
REQ-017 found, exhausted and timeout_err SHALL be registered levels held until the next accepted start; found_nonce/found_hash SHALL hold their last values until overwritten.

Reset
REQ-018 While n_rst=0: state=IDLE; all outputs, counters and latched registers SHALL be 0, asynchronously.
REQ-019 Reset mid-sweep SHALL abandon the sweep with no further core_start; the first start after reset SHALL begin a fresh sweep.

Verification
REQ-020 Bench SHALL cover:
- Win on first nonce: header=0, range 0..0, target=all ones, core returns e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 -> one core_start, core_msg=0, found=1, found_nonce=0, found_hash=that digest.
- Exhaust: target=0, range 5..7 -> three core_starts with nonce fields 5, 6, 7, each launch 2 cycles after the previous done; exhausted=1, found=0.
- Wrap: range FFFFFFFE..00000001, target=0 -> nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001; then exhausted.
- Equal/less: core_hash equals target on nonce 3, then target-1 on nonce 4 (range 3..9) -> found_nonce=4.
- Timeout: core_done never asserted, TIMEOUT=300 -> timeout_err=1 after 300 WAIT cycles; busy=0.
- Abort/reset: abort in WAIT together with core_done -> IDLE, no CHECK; n_rst pulsed mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/nonce_sequencer.sv
// rtl/nonce_sequencer.sv - sweeps a nonce range through a SHA core and stops on the first digest below target
module nonce_sequencer #(
    parameter int TIMEOUT = 300
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [375:0] header_in,
    input  logic [255:0] target_in,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    output logic         core_start,
    output logic [407:0] core_msg,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout_err,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUST, ERROR
    } state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic [375:0]   hdr_r;
    logic [255:0]   tgt_r;
    logic [255:0]   hash_r;
    logic [31:0]    cur_nonce;
    logic [31:0]    last_nonce;
    logic [9:0]     wait_cnt;
    logic           win;
    logic           at_last;
    logic           wait_expired;

    assign win          = hash_r < tgt_r;
    assign at_last      = cur_nonce == last_nonce;
    assign wait_expired = wait_cnt == TMO_LAST;

    // The message is built from latched state only, so it cannot move while the core works on it.
    assign core_msg   = {hdr_r, cur_nonce};
    assign core_start = state == ISSUE;
    assign busy       = (state == ISSUE) || (state == WAIT) || (state == CHECK);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FOUND, EXHAUST, ERROR: if (start) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (core_done)         state_nxt = CHECK;
                else if (wait_expired) state_nxt = ERROR;
            end
            CHECK: begin
                if (win)          state_nxt = FOUND;
                else if (at_last) state_nxt = EXHAUST;
                else              state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hdr_r       <= '0;
            tgt_r       <= '0;
            hash_r      <= '0;
            cur_nonce   <= '0;
            last_nonce  <= '0;
            wait_cnt    <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else if (!abort) begin
            case (state)
                IDLE, FOUND, EXHAUST, ERROR: begin
                    if (start) begin
                        hdr_r       <= header_in;
                        tgt_r       <= target_in;
                        cur_nonce   <= nonce_first;
                        last_nonce  <= nonce_last;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (core_done)         hash_r      <= core_hash;
                    else if (wait_expired) timeout_err <= 1'b1;
                    else                   wait_cnt    <= wait_cnt + 10'd1;
                end
                CHECK: begin
                    if (win) begin
                        found       <= 1'b1;
                        found_nonce <= cur_nonce;
                        found_hash  <= hash_r;
                    end else if (at_last) begin
                        exhausted <= 1'b1;
                    end else begin
                        cur_nonce <= cur_nonce + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sequencer.sv
// tb/tb_nonce_sequencer.sv - directed bench for nonce_sequencer
module tb_nonce_sequencer;

    localparam int TMO = 300;
    localparam logic [255:0] DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [375:0] header_in = '0;
    logic [255:0] target_in = '0;
    logic [31:0]  nonce_first = '0;
    logic [31:0]  nonce_last = '0;
    logic         core_done = 1'b0;
    logic [255:0] core_hash = '0;
    logic         core_start;
    logic [407:0] core_msg;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout_err;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;

    logic [375:0] hdr_a;
    logic [375:0] hdr_b;
    logic [255:0] t_val;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    nonce_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .header_in(header_in), .target_in(target_in),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .core_start(core_start), .core_msg(core_msg),
        .core_done(core_done), .core_hash(core_hash),
        .busy(busy), .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
        .found_nonce(found_nonce), .found_hash(found_hash)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_start) n_starts <= n_starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [375:0] h, input logic [255:0] t,
                          input logic [31:0] f, input logic [31:0] l);
        header_in = h; target_in = t; nonce_first = f; nonce_last = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in ISSUE; returns in CHECK after a one-cycle done in the first WAIT cycle.
    task automatic respond(input logic [255:0] h);
        tick();
        core_done = 1'b1; core_hash = h;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #3;
        checks++; if ({busy, core_start, found, exhausted, timeout_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, core_start, found, exhausted, timeout_err}); end
        checks++; if (core_msg !== 408'b0) begin errors++; $display("FAIL reset_msg: got %h expected 0", core_msg); end
        checks++; if ({found_nonce, found_hash} !== 288'b0) begin errors++; $display("FAIL reset_found: got %h expected 0", {found_nonce, found_hash}); end
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_win_first();
        int s0;
        s0 = n_starts;
        launch('0, '1, 32'd0, 32'd0);
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL win_start: got %b expected 1", core_start); end
        checks++; if (core_msg !== 408'b0) begin errors++; $display("FAIL win_msg: got %h expected 0", core_msg); end
        respond(DIGEST);
        tick();
        checks++; if ({found, busy, exhausted} !== 3'b100) begin errors++; $display("FAIL win_flags: got %b expected 100", {found, busy, exhausted}); end
        checks++; if (found_nonce !== 32'd0) begin errors++; $display("FAIL win_nonce: got %h expected 0", found_nonce); end
        checks++; if (found_hash !== DIGEST) begin errors++; $display("FAIL win_hash: got %h expected %h", found_hash, DIGEST); end
        checks++; if (n_starts - s0 !== 1) begin errors++; $display("FAIL win_count: got %0d expected 1", n_starts - s0); end
    endtask

    task automatic test_exhaust();
        int s0;
        s0 = n_starts;
        launch(hdr_a, '0, 32'd5, 32'd7);
        for (int i = 0; i < 3; i++) begin
            checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL exh_start%0d: got %b expected 1", i, core_start); end
            checks++; if (core_msg !== {hdr_a, 32'd5 + 32'(i)}) begin errors++; $display("FAIL exh_msg%0d: got %h expected %h", i, core_msg, {hdr_a, 32'd5 + 32'(i)}); end
            tick();
            if (i == 0) begin
                start = 1'b1; header_in = ~hdr_a; nonce_first = 32'd100; target_in = '1;
                tick();
                start = 1'b0;
                checks++; if (core_msg !== {hdr_a, 32'd5}) begin errors++; $display("FAIL exh_ignore: got %h expected %h", core_msg, {hdr_a, 32'd5}); end
            end
            core_done = 1'b1; core_hash = 256'h1234;
            tick();
            core_done = 1'b0;
            checks++; if ({core_start, busy} !== 2'b01) begin errors++; $display("FAIL exh_gap%0d: got %b expected 01", i, {core_start, busy}); end
            tick();
        end
        checks++; if ({exhausted, found, busy} !== 3'b100) begin errors++; $display("FAIL exh_flags: got %b expected 100", {exhausted, found, busy}); end
        checks++; if (n_starts - s0 !== 3) begin errors++; $display("FAIL exh_count: got %0d expected 3", n_starts - s0); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_n [4];
        int s0;
        exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        s0 = n_starts;
        launch(hdr_b, '0, 32'hFFFFFFFE, 32'h00000001);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({core_start, core_msg[31:0]} !== {1'b1, exp_n[i]}) begin errors++; $display("FAIL wrap_nonce%0d: got %b/%h expected 1/%h", i, core_start, core_msg[31:0], exp_n[i]); end
            respond(256'h1);
            tick();
        end
        checks++; if ({exhausted, found, busy} !== 3'b100) begin errors++; $display("FAIL wrap_flags: got %b expected 100", {exhausted, found, busy}); end
        checks++; if (n_starts - s0 !== 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", n_starts - s0); end
    endtask

    task automatic test_equal_less();
        t_val = {16'h0001, 240'h0};
        launch(hdr_b, t_val, 32'd3, 32'd9);
        checks++; if (core_msg[31:0] !== 32'd3) begin errors++; $display("FAIL eq_nonce3: got %h expected 3", core_msg[31:0]); end
        respond(t_val);
        tick();
        checks++; if ({core_start, found, core_msg[31:0]} !== {2'b10, 32'd4}) begin errors++; $display("FAIL eq_not_win: got %h expected %h", {core_start, found, core_msg[31:0]}, {2'b10, 32'd4}); end
        respond(t_val - 256'd1);
        tick();
        checks++; if ({found, exhausted, busy} !== 3'b100) begin errors++; $display("FAIL lt_flags: got %b expected 100", {found, exhausted, busy}); end
        checks++; if (found_nonce !== 32'd4) begin errors++; $display("FAIL lt_nonce: got %h expected 4", found_nonce); end
        checks++; if (found_hash !== t_val - 256'd1) begin errors++; $display("FAIL lt_hash: got %h expected %h", found_hash, t_val - 256'd1); end
    endtask

    task automatic test_timeout();
        launch('0, '1, 32'd10, 32'd20);
        tick();
        repeat (TMO - 1) tick();
        checks++; if ({busy, timeout_err} !== 2'b10) begin errors++; $display("FAIL tmo_last_wait: got %b expected 10", {busy, timeout_err}); end
        tick();
        checks++; if ({busy, timeout_err, found} !== 3'b010) begin errors++; $display("FAIL tmo_error: got %b expected 010", {busy, timeout_err, found}); end
        checks++; if (found_nonce !== 32'd4) begin errors++; $display("FAIL tmo_hold_nonce: got %h expected 4", found_nonce); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({busy, timeout_err} !== 2'b01) begin errors++; $display("FAIL tmo_abort_hold: got %b expected 01", {busy, timeout_err}); end
    endtask

    task automatic test_abort();
        int s0;
        launch('0, '1, 32'd0, 32'd3);
        tick();
        abort = 1'b1; start = 1'b1; core_done = 1'b1; core_hash = '0;
        tick();
        abort = 1'b0; start = 1'b0; core_done = 1'b0;
        checks++; if ({busy, found, timeout_err} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b expected 000", {busy, found, timeout_err}); end
        s0 = n_starts;
        repeat (4) tick();
        checks++; if ({n_starts - s0, found, busy} !== {32'd0, 2'b00}) begin errors++; $display("FAIL abort_quiet: got %0d/%b%b expected 0/00", n_starts - s0, found, busy); end
    endtask

    task automatic test_reset_mid();
        int s0;
        launch(hdr_a, '0, 32'd40, 32'd50);
        tick();
        s0 = n_starts;
        #2;
        n_rst = 1'b0;
        #1;
        checks++; if ({busy, core_start, core_msg} !== 410'b0) begin errors++; $display("FAIL rst_mid_msg: got %h expected 0", {busy, core_start, core_msg}); end
        checks++; if ({found_nonce, found_hash} !== 288'b0) begin errors++; $display("FAIL rst_mid_found: got %h expected 0", {found_nonce, found_hash}); end
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (3) tick();
        checks++; if ({n_starts - s0, busy} !== {32'd0, 1'b0}) begin errors++; $display("FAIL rst_mid_quiet: got %0d/%b expected 0/0", n_starts - s0, busy); end
        launch(hdr_a, '0, 32'd60, 32'd60);
        checks++; if ({core_start, core_msg} !== {1'b1, hdr_a, 32'd60}) begin errors++; $display("FAIL rst_fresh: got %h expected %h", {core_start, core_msg}, {1'b1, hdr_a, 32'd60}); end
        respond(256'h5);
        tick();
        checks++; if ({exhausted, busy} !== 2'b10) begin errors++; $display("FAIL rst_fresh_exh: got %b expected 10", {exhausted, busy}); end
    endtask

    initial begin
        hdr_a = {47{8'hA5}};
        hdr_b = {47{8'h3C}};
        test_reset();
        test_win_first();
        test_exhaust();
        test_wrap();
        test_equal_less();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1);
    end

endmodule
